// File: rtl/cpu_clk_ctrl.sv
// CPU clock sequencer: glitch-free fast/slow tap selection, pause, and
// debounced single-step, with a registered Clk_CPU that never emits runt pulses.
module cpu_clk_ctrl #(
   parameter int FAST_BIT    = 3,
   parameter int SLOW_BIT    = 23,
   parameter int DB_CYCLES   = 16,
   parameter int STEP_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] clkdiv,
   input  logic        SW2,
   input  logic        SW_Pause,
   input  logic        BTN_Step,
   output logic        Clk_CPU,
   output logic        cpu_rise,
   output logic        paused,
   output logic [15:0] step_cnt
);

   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int PHW = $clog2(STEP_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES);
   localparam logic [PHW-1:0] STEP_LAST = PHW'(STEP_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_RUN     = 3'd0,
      ST_PAUSED  = 3'd1,
      ST_STEP_HI = 3'd2,
      ST_STEP_LO = 3'd3,
      ST_RESUME  = 3'd4
   } state_t;

   state_t           state_r;
   logic [1:0]       sw2_sync_r;
   logic [1:0]       pause_sync_r;
   logic [1:0]       btn_sync_r;
   logic             sw2_s;
   logic             pause_s;
   logic             btn_s;
   logic [DBW-1:0]   db_cnt_r;
   logic [DBW-1:0]   db_inc_s;
   logic             btn_db_r;
   logic             btn_db_d_r;
   logic             step_req_s;
   logic             tap_sel_r;
   logic             tap_s;
   logic             clk_nx_s;
   logic [PHW-1:0]   ph_cnt_r;
   logic             clkdiv_unused_s;

   assign sw2_s      = sw2_sync_r[1];
   assign pause_s    = pause_sync_r[1];
   assign btn_s      = btn_sync_r[1];
   assign db_inc_s   = db_cnt_r + DBW'(1);
   assign step_req_s = btn_db_r & ~btn_db_d_r;
   assign tap_s      = tap_sel_r ? clkdiv[SLOW_BIT] : clkdiv[FAST_BIT];
   assign paused     = (state_r == ST_PAUSED) || (state_r == ST_STEP_HI) ||
                       (state_r == ST_STEP_LO);
   assign clkdiv_unused_s = ^clkdiv;

   // Two-flop synchronizers for the asynchronous switch and button inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sw2_sync_r   <= 2'b00;
         pause_sync_r <= 2'b00;
         btn_sync_r   <= 2'b00;
      end else begin
         sw2_sync_r   <= {sw2_sync_r[0], SW2};
         pause_sync_r <= {pause_sync_r[0], SW_Pause};
         btn_sync_r   <= {btn_sync_r[0], BTN_Step};
      end
   end

   // Button debounce: a new level is accepted after DB_CYCLES stable cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt_r   <= '0;
         btn_db_r   <= 1'b0;
         btn_db_d_r <= 1'b0;
      end else begin
         btn_db_d_r <= btn_db_r;
         if (btn_s == btn_db_r) begin
            db_cnt_r <= '0;
         end else if (db_inc_s == DB_LAST) begin
            btn_db_r <= btn_s;
            db_cnt_r <= '0;
         end else begin
            db_cnt_r <= db_inc_s;
         end
      end
   end

   // Tap switches only while both taps and the output are low, so no phase is cut short
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_sel_r <= 1'b0;
      end else if (!Clk_CPU && !clkdiv[FAST_BIT] && !clkdiv[SLOW_BIT]) begin
         tap_sel_r <= sw2_s;
      end else begin
         tap_sel_r <= tap_sel_r;
      end
   end

   // Next value of Clk_CPU, shared by the output register and the rise detector
   always_comb begin
      clk_nx_s = 1'b0;
      case (state_r)
         ST_RUN:     clk_nx_s = tap_s;
         ST_PAUSED:  clk_nx_s = step_req_s;
         ST_STEP_HI: clk_nx_s = (ph_cnt_r != STEP_LAST);
         ST_STEP_LO: clk_nx_s = 1'b0;
         ST_RESUME:  clk_nx_s = 1'b0;
         default:    clk_nx_s = 1'b0;
      endcase
   end

   // Sequencing state machine with registered clock and step outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_RUN;
         Clk_CPU  <= 1'b0;
         cpu_rise <= 1'b0;
         step_cnt <= 16'd0;
         ph_cnt_r <= '0;
      end else begin
         Clk_CPU  <= clk_nx_s;
         cpu_rise <= clk_nx_s & ~Clk_CPU;
         case (state_r)
            ST_RUN: begin
               if (pause_s && !Clk_CPU && !tap_s) state_r <= ST_PAUSED;
            end
            ST_PAUSED: begin
               if (step_req_s) begin
                  state_r  <= ST_STEP_HI;
                  ph_cnt_r <= '0;
               end else if (!pause_s) begin
                  state_r <= ST_RESUME;
               end
            end
            ST_STEP_HI: begin
               if (ph_cnt_r == STEP_LAST) begin
                  state_r  <= ST_STEP_LO;
                  ph_cnt_r <= '0;
               end else begin
                  ph_cnt_r <= ph_cnt_r + PHW'(1);
               end
            end
            ST_STEP_LO: begin
               if (ph_cnt_r == STEP_LAST) begin
                  state_r  <= ST_PAUSED;
                  ph_cnt_r <= '0;
                  step_cnt <= step_cnt + 16'd1;
               end else begin
                  ph_cnt_r <= ph_cnt_r + PHW'(1);
               end
            end
            ST_RESUME: begin
               if (pause_s) state_r <= ST_PAUSED;
               else if (!tap_s) state_r <= ST_RUN;
            end
            default: state_r <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed sequence with randomized timing,
// checked against phase-length and timing rules measured from Clk_CPU.
module tb_cpu_clk_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] clkdiv = 32'd0;
   logic        SW2 = 1'b0;
   logic        SW_Pause = 1'b0;
   logic        BTN_Step = 1'b0;
   logic        Clk_CPU;
   logic        cpu_rise;
   logic        paused;
   logic [15:0] step_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int rise_err = 0;
   int hi_q[$];
   int lo_q[$];
   int run_len  = 0;
   logic last_clk = 1'b0;

   cpu_clk_ctrl #(
      .FAST_BIT(3), .SLOW_BIT(6), .DB_CYCLES(16), .STEP_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst), .clkdiv(clkdiv), .SW2(SW2), .SW_Pause(SW_Pause),
      .BTN_Step(BTN_Step), .Clk_CPU(Clk_CPU), .cpu_rise(cpu_rise),
      .paused(paused), .step_cnt(step_cnt)
   );

   always #5 clk = ~clk;

   // free-running divider sharing the block's reset
   always @(posedge clk) clkdiv <= rst ? 32'd0 : clkdiv + 32'd1;

   // phase-length recorder and rise-pulse consistency monitor
   always @(negedge clk) begin
      if (rst) begin
         run_len  = 0;
         last_clk = 1'b0;
      end else begin
         if (cpu_rise !== (Clk_CPU && !last_clk)) rise_err++;
         if (Clk_CPU !== last_clk) begin
            if (last_clk) hi_q.push_back(run_len);
            else lo_q.push_back(run_len);
            run_len = 1;
         end else begin
            run_len++;
         end
         last_clk = Clk_CPU;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int k, hi, lo, cnt, bad, errs, delay, elapsed, n8, n64, bad_hi, bad_lo, next_tog;
      logic ptap;

      // reset state
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_clk_cpu", Clk_CPU, 0);
      chk("rst_cpu_rise", cpu_rise, 0);
      chk("rst_paused", paused, 0);
      chk("rst_step_cnt", step_cnt, 0);

      // fast run: Clk_CPU is clkdiv[3] one cycle late
      ptap = clkdiv[3];
      rst = 1'b0;
      errs = 0; cnt = 0; bad = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (Clk_CPU !== ptap) errs++;
         if (cpu_rise === 1'b1) cnt++;
         if (paused !== 1'b0) bad++;
         ptap = clkdiv[3];
      end
      chk("run_follow_tap", errs, 0);
      chk("run_rise_count", cnt, 4);
      chk("run_not_paused", bad, 0);

      // pause request during a high phase
      k = 0;
      while (cpu_rise !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      chk("pause_rise_seen", (k < 40), 1);
      delay = $urandom_range(1, 5);
      hi = 0;
      for (int i = 0; i < delay; i++) begin
         if (Clk_CPU === 1'b1) hi++;
         @(negedge clk);
      end
      SW_Pause = 1'b1;
      k = 0;
      while (Clk_CPU === 1'b1 && k < 20) begin hi++; @(negedge clk); k++; end
      chk("pause_high_len", hi, 8);
      cnt = 0; bad = 0;
      for (int i = 0; i < 42; i++) begin
         @(negedge clk);
         if (Clk_CPU !== 1'b0) cnt++;
         if (i >= 2 && paused !== 1'b1) bad++;
      end
      chk("pause_clk_low", cnt, 0);
      chk("pause_flag", bad, 0);

      // single step with a clean 30-cycle press
      BTN_Step = 1'b1;
      k = 0; bad = 0;
      while (Clk_CPU !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      chk("step_delay_19_20", (k >= 19 && k <= 20), 1);
      hi = 0;
      while (Clk_CPU === 1'b1 && hi < 20) begin
         if (paused !== 1'b1) bad++;
         hi++; @(negedge clk);
      end
      chk("step_high_len", hi, 4);
      lo = 0;
      while (step_cnt === 16'd0 && lo < 20) begin
         if (paused !== 1'b1 || Clk_CPU !== 1'b0) bad++;
         lo++; @(negedge clk);
      end
      chk("step_low_len", lo, 4);
      chk("step_cnt_1", step_cnt, 1);
      elapsed = k + hi + lo;
      if (elapsed < 30) repeat (30 - elapsed) @(negedge clk);
      BTN_Step = 1'b0;
      repeat (25) @(negedge clk);
      chk("step_paused_held", bad, 0);
      chk("step_release_nocount", step_cnt, 1);

      // second press preceded by random bounce
      for (int b = 0; b < 4; b++) begin
         BTN_Step = ~BTN_Step;
         repeat ($urandom_range(1, 10)) @(negedge clk);
      end
      BTN_Step = 1'b1;
      k = 0;
      while (step_cnt !== 16'd2 && k < 60) begin @(negedge clk); k++; end
      chk("step_cnt_2", step_cnt, 2);
      repeat (35 - ((k < 35) ? k : 35)) @(negedge clk);
      BTN_Step = 1'b0;
      repeat (25) @(negedge clk);

      // bouncing button never settles long enough
      cnt = 0; bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (i % 5 == 0) BTN_Step = ~BTN_Step;
         @(negedge clk);
         if (Clk_CPU !== 1'b0) cnt++;
      end
      next_tog = 0;
      for (int i = 0; i < 100; i++) begin
         if (next_tog == 0) begin
            BTN_Step = ~BTN_Step;
            next_tog = $urandom_range(1, 12);
         end
         next_tog--;
         @(negedge clk);
         if (Clk_CPU !== 1'b0) cnt++;
      end
      BTN_Step = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (Clk_CPU !== 1'b0) cnt++;
         if (paused !== 1'b1) bad++;
      end
      chk("bounce_no_pulse", cnt, 0);
      chk("bounce_step_cnt", step_cnt, 2);
      chk("bounce_paused", bad, 0);

      // resume and random speed switching
      SW_Pause = 1'b0;
      SW2 = 1'b1;
      hi_q.delete();
      lo_q.delete();
      next_tog = 600;
      for (int i = 0; i < 5000; i++) begin
         if (next_tog == 0) begin
            SW2 = ~SW2;
            next_tog = $urandom_range(150, 700);
         end
         next_tog--;
         @(negedge clk);
      end
      chk("speed_not_paused", paused, 0);
      n8 = 0; n64 = 0; bad_hi = 0; bad_lo = 0;
      foreach (hi_q[i]) begin
         if (hi_q[i] == 8) n8++;
         else if (hi_q[i] == 64) n64++;
         else bad_hi++;
      end
      foreach (lo_q[i]) if (lo_q[i] < 8) bad_lo++;
      chk("speed_bad_high", bad_hi, 0);
      chk("speed_bad_low", bad_lo, 0);
      chk("speed_fast_seen", (n8 > 0), 1);
      chk("speed_slow_seen", (n64 > 0), 1);

      // reset in the middle of a step
      SW2 = 1'b0;
      SW_Pause = 1'b1;
      k = 0;
      while (paused !== 1'b1 && k < 400) begin @(negedge clk); k++; end
      chk("midstep_paused", paused, 1);
      BTN_Step = 1'b1;
      k = 0;
      while (Clk_CPU !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      chk("midstep_in_step_hi", Clk_CPU, 1);
      @(negedge clk);
      rst = 1'b1;
      SW_Pause = 1'b0;
      BTN_Step = 1'b0;
      @(negedge clk);
      chk("midstep_rst_clk", Clk_CPU, 0);
      chk("midstep_rst_paused", paused, 0);
      chk("midstep_rst_cnt", step_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      while (cpu_rise !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      chk("postrst_rise_seen", (k < 40), 1);
      hi = 0; k = 0;
      while (Clk_CPU === 1'b1 && k < 20) begin hi++; @(negedge clk); k++; end
      chk("postrst_high_len", hi, 8);
      chk("postrst_step_cnt", step_cnt, 0);

      chk("cpu_rise_consistent", rise_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
